// File: rtl/fir_coef_if.sv
// Coefficient stream from host/config logic to the FIR coefficient loader.
// Carries s_chk only when COEF_CHECKSUM_EN is defined.
interface fir_coef_if #(
  parameter int unsigned CEL = 4
) ();
  logic           start;
  logic           s_valid;
  logic           s_ready;
  logic [CEL-1:0] s_data;
  logic           s_last;
`ifdef COEF_CHECKSUM_EN
  logic [CEL-1:0] s_chk;

  modport master (output start, s_valid, s_data, s_last, s_chk, input s_ready);
  modport slave  (input start, s_valid, s_data, s_last, s_chk, output s_ready);
`else
  modport master (output start, s_valid, s_data, s_last, input s_ready);
  modport slave  (input start, s_valid, s_data, s_last, output s_ready);
`endif
endinterface

// File: rtl/fir_coef_loader.sv
// Serial loader for the FIR packed coefficient bus: stages taps in a shadow
// register and commits them atomically. COEF_CHECKSUM_EN adds a beat checksum.
module fir_coef_loader #(
  parameter int unsigned CEL = 4,
  parameter int unsigned IPD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_coef_if.slave          bus,
  output logic [CEL*IPD-1:0] c,
  output logic               c_update,
  output logic               busy,
  output logic               err
);
  localparam int unsigned IW = $clog2(IPD) + 1;
  localparam int unsigned CW = CEL * IPD;
  localparam logic [IW-1:0] LAST_IDX = IW'(IPD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n;
  logic [CW-1:0]  shadow, shadow_n;
  logic [CW-1:0]  c_n;
  logic           c_update_n, busy_n, err_n;
  logic           ready, ready_n;
`ifdef COEF_CHECKSUM_EN
  logic [CEL-1:0] sum, sum_n;
`endif

  assign bus.s_ready = ready;

  // State and datapath registers; reset also discards any partial set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      shadow   <= '0;
      c        <= '0;
      c_update <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ready    <= 1'b0;
`ifdef COEF_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      shadow   <= shadow_n;
      c        <= c_n;
      c_update <= c_update_n;
      busy     <= busy_n;
      err      <= err_n;
      ready    <= ready_n;
`ifdef COEF_CHECKSUM_EN
      sum      <= sum_n;
`endif
    end
  end

  // Next-state, shadow staging and commit.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    shadow_n   = shadow;
    c_n        = c;
    c_update_n = 1'b0;
    err_n      = err;
`ifdef COEF_CHECKSUM_EN
    sum_n      = sum;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = LOAD;
          idx_n   = '0;
          err_n   = 1'b0;
`ifdef COEF_CHECKSUM_EN
          sum_n   = '0;
`endif
        end
      end
      LOAD: begin
        if (bus.start) begin
          // Restart wins over a beat presented in the same cycle.
          idx_n = '0;
`ifdef COEF_CHECKSUM_EN
          sum_n = '0;
`endif
        end else if (bus.s_valid) begin
          for (int unsigned k = 0; k < IPD; k++) begin
            if (idx == IW'(k)) shadow_n[k*CEL +: CEL] = bus.s_data;
          end
          idx_n = idx + IW'(1);
`ifdef COEF_CHECKSUM_EN
          sum_n = sum + bus.s_data;
`endif
          if (idx == LAST_IDX) begin
            if (!bus.s_last) begin
              err_n   = 1'b1;
              state_n = IDLE;
`ifdef COEF_CHECKSUM_EN
            end else if (sum_n != bus.s_chk) begin
              err_n   = 1'b1;
              state_n = IDLE;
`endif
            end else begin
              state_n = COMMIT;
            end
          end else if (bus.s_last) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      COMMIT: begin
        c_n        = shadow;
        c_update_n = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == LOAD);
  end
endmodule
